sqr_iter: RTL and testbench

SQR_ITER -- requirements
Module: sqr_iter

---
 rtl/sqr_iter.sv | 93 +++++++++
 tb/tb_sqr_iter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqr_iter.sv
// sqr_iter: iterative 8x8 unsigned squarer, one shift-add step per clock (8 CALC cycles).
// Optional macro SQR_ABORT_EN: x_ready during CALC restarts the operation with the new operand.
//
// state  | meaning
// IDLE   | waiting for x_ready; y_out/y_ready hold the last result
// CALC   | one partial product accumulated per edge, LSB first
module sqr_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  x_in,
    input  logic        x_ready,
    output logic [15:0] y_out,
    output logic        y_ready,
    output logic        busy
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_CALC = 1'b1;

    logic        state_q,   state_d;
    logic [7:0]  operand_q, operand_d;
    logic [15:0] acc_q,     acc_d;
    logic [2:0]  cnt_q,     cnt_d;
    logic [15:0] y_out_q,   y_out_d;
    logic        y_ready_q, y_ready_d;
    logic        busy_q,    busy_d;

    logic        start;
    logic [15:0] partial;
    logic [15:0] sum;

    always_comb begin
`ifdef SQR_ABORT_EN
        start = x_ready;
`else
        start = x_ready && (state_q == S_IDLE);
`endif
        partial = operand_q[cnt_q] ? ({8'd0, operand_q} << cnt_q) : 16'd0;
        // 255*255 fits in 16 bits, so the sum never needs a carry-out
        sum     = acc_q + partial;

        state_d   = state_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        y_out_d   = y_out_q;
        y_ready_d = y_ready_q;
        busy_d    = busy_q;

        if (start) begin
            operand_d = x_in;
            acc_d     = 16'd0;
            cnt_d     = 3'd0;
            y_ready_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_CALC;
        end else if (state_q == S_CALC) begin
            acc_d = sum;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                y_out_d   = sum;
                y_ready_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            operand_q <= 8'd0;
            acc_q     <= 16'd0;
            cnt_q     <= 3'd0;
            y_out_q   <= 16'd0;
            y_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            y_out_q   <= y_out_d;
            y_ready_q <= y_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign y_out   = y_out_q;
    assign y_ready = y_ready_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sqr_iter.sv
// Self-checking bench for sqr_iter; expected squares go through a queue and are popped on y_ready.
// Build with SQR_ABORT_EN defined to check the restart-in-CALC variant.
module tb_sqr_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  x_in;
    logic        x_ready;
    logic [15:0] y_out;
    logic        y_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    sqr_iter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_in    (x_in),
        .x_ready (x_ready),
        .y_out   (y_out),
        .y_ready (y_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Waits on falling edges until y_ready is seen; n = edges waited, ok = 0 on timeout.
    task automatic wait_ready(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (y_ready === 1'b1) ok = 1'b1;
        end
    endtask

    // Drives a one-cycle x_ready pulse; returns at the falling edge after the accept edge.
    task automatic pulse_start(input logic [7:0] v);
        x_in    = v;
        x_ready = 1'b1;
        @(negedge clk);
        x_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        x_ready = 1'b0;
        x_in    = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (y_out !== 16'd0 || y_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got y_out=%0d y_ready=%b busy=%b, want 0 0 0", y_out, y_ready, busy);
        end
        x_in    = 8'd77;
        x_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || y_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_over_accept: got busy=%b y_ready=%b, want 0 0", busy, y_ready);
        end
    endtask

    task automatic test_basic();
        int n, busy_cnt;
        bit ok, hold_bad;
        logic [15:0] e;
        // First edge with rst_n=1 accepts immediately
        rst_n = 1'b1;
        exp_q.push_back(16'd41209);
        pulse_start(8'd203);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_accept: got busy=%b, want 1", busy);
        end
        busy_cnt = 1;
        hold_bad = 1'b0;
        n = 0;
        while (y_ready !== 1'b1 && n < 20) begin
            if (y_out !== 16'd0) hold_bad = 1'b1;
            @(negedge clk);
            n++;
            if (busy === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 8 || n != 8) begin
            n_fail++;
            $display("FAIL basic_latency: got busy_cycles=%0d ready_after=%0d, want 8 8", busy_cnt, n);
        end
        n_checks++;
        if (hold_bad) begin
            n_fail++;
            $display("FAIL y_out_hold_calc: y_out changed during CALC, want 0");
        end
        e = exp_q.pop_front();
        n_checks++;
        if (y_out !== e || y_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_203: got y_out=%0d y_ready=%b busy=%b, want %0d 1 0", y_out, y_ready, busy, e);
        end
        x_in = 8'd9;
        repeat (4) @(negedge clk);
        n_checks++;
        if (y_out !== e || y_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got y_out=%0d y_ready=%b busy=%b, want %0d 1 0", y_out, y_ready, busy, e);
        end
        ok = 1'b1;
    endtask

    task automatic test_corners();
        logic [7:0] vals [3];
        int n;
        bit ok;
        logic [15:0] e;
        vals[0] = 8'd0;
        vals[1] = 8'd255;
        vals[2] = 8'd1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'(vals[i]) * 16'(vals[i]));
            pulse_start(vals[i]);
            n_checks++;
            if (y_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_clear_%0d: got y_ready=%b, want 0", vals[i], y_ready);
            end
            wait_ready(20, n, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || n != 8 || y_out !== e) begin
                n_fail++;
                $display("FAIL corner_%0d: got y_out=%0d after %0d cycles (ok=%b), want %0d after 8", vals[i], y_out, n, ok, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, ready_cnt;
        bit ok;
        logic [15:0] e;
        exp_q.push_back(16'd225);
        exp_q.push_back(16'd256);
        x_in    = 8'd15;
        x_ready = 1'b1;
        @(negedge clk);
        x_in = 8'd16;
`ifdef SQR_ABORT_EN
        x_ready = 1'b0;
`endif
        wait_ready(20, n, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || y_out !== e) begin
            n_fail++;
            $display("FAIL b2b_first: got y_out=%0d (ok=%b), want %0d", y_out, ok, e);
        end
        x_ready   = 1'b1;
        ready_cnt = 1;
        @(negedge clk);
        x_ready = 1'b0;
        if (y_ready === 1'b1) ready_cnt++;
        n_checks++;
        if (ready_cnt != 1 || busy !== 1'b1 || y_out !== e) begin
            n_fail++;
            $display("FAIL b2b_gap: got ready_cycles=%0d busy=%b y_out=%0d, want 1 1 %0d", ready_cnt, busy, y_out, e);
        end
        wait_ready(20, n, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || n != 8 || y_out !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got y_out=%0d after %0d (ok=%b), want %0d after 8", y_out, n, ok, e);
        end
    endtask

    task automatic test_reset_mid_calc();
        int n;
        bit ok;
        pulse_start(8'd100);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (y_out !== 16'd0 || y_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got y_out=%0d y_ready=%b busy=%b, want 0 0 0", y_out, y_ready, busy);
        end
        rst_n = 1'b1;
        wait_ready(15, n, ok);
        n_checks++;
        if (ok || y_out !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got y_ready_seen=%b y_out=%0d busy=%b, want 0 0 0", ok, y_out, busy);
        end
    endtask

    task automatic test_x_in_change();
        int n;
        bit ok;
        logic [15:0] e;
        exp_q.push_back(16'd144);
        pulse_start(8'd12);
        repeat (2) @(negedge clk);
        x_in = 8'd200;
        wait_ready(20, n, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || y_out !== e) begin
            n_fail++;
            $display("FAIL x_in_change: got y_out=%0d (ok=%b), want %0d", y_out, ok, e);
        end
    endtask

    task automatic test_ready_in_calc();
        int n, exp_n;
        bit ok;
        logic [15:0] e;
`ifdef SQR_ABORT_EN
        exp_q.push_back(16'd400);
        exp_n = 13;
`else
        exp_q.push_back(16'd100);
        exp_n = 8;
`endif
        pulse_start(8'd10);
        repeat (4) @(negedge clk);
        x_in    = 8'd20;
        x_ready = 1'b1;
        @(negedge clk);
        x_ready = 1'b0;
        wait_ready(20, n, ok);
        n = n + 5;
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || n != exp_n || y_out !== e) begin
            n_fail++;
            $display("FAIL ready_in_calc: got y_out=%0d at edge %0d (ok=%b), want %0d at %0d", y_out, n, ok, e, exp_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_reset_mid_calc();
        test_x_in_change();
        test_ready_in_calc();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
